// File: rtl/shift_ctrl_pkg.sv
// Shared encodings for the shift command controller: command ops, FSM states, step direction.
package shift_ctrl_pkg;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_SHR  = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_LOAD  = 2'b01;
    localparam logic [1:0] ST_SHIFT = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate step; WIDTH must be at least 2.
import shift_ctrl_pkg::*;

module shift_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] value,
    input  dir_t             dir,
    input  logic             rotate,
    output logic [WIDTH-1:0] result
);

    // Left steps always zero-fill; rotate only affects the right direction.
    always_comb begin
        result = value;
        if (dir == DIR_LEFT) begin
            result = {value[WIDTH-2:0], 1'b0};
        end else begin
            result = {(rotate ? value[0] : 1'b0), value[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/shift_cmd_ctrl.sv
// Command sequencer: LOAD/SHL/SHR executed one bit per clock with a one-cycle done pulse.
// Define SHIFT_CTRL_ROTATE_EN to turn op 11 into rotate-right instead of zero-fill shift-right.
import shift_ctrl_pkg::*;

module shift_cmd_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             cmd_err
);

    logic [1:0]       state;
    logic [1:0]       op_r;
    logic [CNT_W-1:0] remaining;
    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] step_result;
    logic             accept;
    logic             rotate_en;

`ifdef SHIFT_CTRL_ROTATE_EN
    assign rotate_en = 1'b1;
`else
    assign rotate_en = 1'b0;
`endif

    assign cmd_ready = (state == ST_IDLE) && !reset;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    // Every 2-bit op is decoded, so no error can arise; the port stays for wider encodings.
    assign cmd_err   = 1'b0;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .value  (q),
        .dir    ((op_r == OP_SHL) ? DIR_LEFT : DIR_RIGHT),
        .rotate (rotate_en),
        .result (step_result)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            q         <= '0;
            op_r      <= OP_NOP;
            remaining <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_r      <= cmd_op;
                        remaining <= cmd_amt;
                        case (cmd_op)
                            OP_LOAD: state <= ST_LOAD;
                            OP_SHL, OP_SHR:
                                state <= (cmd_amt == '0) ? ST_DONE : ST_SHIFT;
                            default: state <= ST_DONE;
                        endcase
                    end
                end
                ST_LOAD: begin
                    q     <= data_r;
                    state <= ST_DONE;
                end
                ST_SHIFT: begin
                    q         <= step_result;
                    remaining <= remaining - 1'b1;
                    if (remaining == CNT_W'(1)) begin
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: load data is only read after a capture, so this register needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_r <= cmd_data;
        end
    end

endmodule
